// File: rtl/if_stage.sv
// Instruction fetch stage: program counter, combinational instruction ROM and
// the IF/ID pipeline register with stall, flush and redirect handling.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_DEPTH = 1024,
    parameter logic [31:0] NOP       = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        flush_id,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_instruction,
    output logic        id_valid,
    output logic        misaligned_err,
    output logic [31:0] fetch_count
);

    localparam int          AW      = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam logic [31:0] DEPTH_W = ROM_DEPTH;

    // Contents are loaded from outside the design; nothing in here writes it.
    logic [31:0] rom_memory [0:ROM_DEPTH-1];

    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic [31:0] word_idx;
    logic        in_range;
    logic        bubble;

    assign if_pc    = pc_q;
    assign pc_plus4 = pc_q + 32'd4;
    assign word_idx = {2'b00, pc_q[31:2]};
    assign in_range = word_idx < DEPTH_W;

    // Addresses past the end of the ROM fetch a NOP rather than garbage.
    assign if_instruction = in_range ? rom_memory[word_idx[AW-1:0]] : NOP;

    // A taken redirect squashes whatever IF currently holds.
    assign bubble = flush_id | redirect_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= {redirect_target[31:2], 2'b00};
        end else if (!stall_if) begin
            pc_q <= pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pc          <= 32'h0;
            id_pc_plus4    <= 32'h0;
            id_instruction <= NOP;
            id_valid       <= 1'b0;
            fetch_count    <= 32'h0;
        end else if (bubble) begin
            id_instruction <= NOP;
            id_valid       <= 1'b0;
        end else if (!stall_id) begin
            id_pc          <= pc_q;
            id_pc_plus4    <= pc_plus4;
            id_instruction <= if_instruction;
            id_valid       <= 1'b1;
            fetch_count    <= fetch_count + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misaligned_err <= 1'b0;
        end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
            misaligned_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: linear fetch, redirect, stalls, flush,
// misaligned and out-of-range redirects, PC wrap and asynchronous reset.
module tb_if_stage;

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall_if;
    logic        stall_id;
    logic        flush_id;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instruction;
    logic        id_valid;
    logic        misaligned_err;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .ROM_DEPTH(1024),
        .NOP      (NOP_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_if       (stall_if),
        .stall_id       (stall_id),
        .flush_id       (flush_id),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_instruction (id_instruction),
        .id_valid       (id_valid),
        .misaligned_err (misaligned_err),
        .fetch_count    (fetch_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM image: word i is "addi x1, x0, i"
    function automatic logic [31:0] rom_word(input int i);
        return 32'h0000_0093 | (32'(i) << 20);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_if        = 1'b0;
        stall_id        = 1'b0;
        flush_id        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid  = 1'b1;
        redirect_target = target;
        step();
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc: got %h want %h", if_pc, 32'h0); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc: got %h want %h", id_pc, 32'h0); end
        checks++; if (id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_id_pc_plus4: got %h want %h", id_pc_plus4, 32'h0); end
        checks++; if (id_instruction !== NOP_W) begin errors++; $display("FAIL reset_id_instr: got %h want %h", id_instruction, NOP_W); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b want 0", id_valid); end
        checks++; if (misaligned_err !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b want 0", misaligned_err); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_fetch_count: got %h want 0", fetch_count); end
        rst = 1'b1;
    endtask

    task automatic test_linear();
        logic [31:0] exp_w;
        reset_dut();
        checks++; if (if_instruction !== rom_word(0)) begin errors++; $display("FAIL lin_if_instr0: got %h want %h", if_instruction, rom_word(0)); end
        for (int i = 0; i < 3; i++) exp_q.push_back(rom_word(i));
        for (int i = 0; i < 3; i++) begin
            step();
            exp_w = exp_q.pop_front();
            checks++; if (id_instruction !== exp_w) begin errors++; $display("FAIL lin_id_instr%0d: got %h want %h", i, id_instruction, exp_w); end
            checks++; if (id_pc !== 32'(i * 4)) begin errors++; $display("FAIL lin_id_pc%0d: got %h want %h", i, id_pc, 32'(i * 4)); end
        end
        checks++; if (if_pc !== 32'h0C) begin errors++; $display("FAIL lin_if_pc: got %h want %h", if_pc, 32'h0C); end
        checks++; if (id_pc_plus4 !== 32'h0C) begin errors++; $display("FAIL lin_id_pc_plus4: got %h want %h", id_pc_plus4, 32'h0C); end
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL lin_id_valid: got %b want 1", id_valid); end
        checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL lin_fetch_count: got %h want 3", fetch_count); end
    endtask

    task automatic test_redirect();
        reset_dut();
        step();
        step();
        checks++; if (if_pc !== 32'h08) begin errors++; $display("FAIL rd_pre_pc: got %h want %h", if_pc, 32'h08); end
        redirect_to(32'h20);
        checks++; if (if_pc !== 32'h20) begin errors++; $display("FAIL rd_if_pc: got %h want %h", if_pc, 32'h20); end
        checks++; if (if_instruction !== rom_word(8)) begin errors++; $display("FAIL rd_if_instr: got %h want %h", if_instruction, rom_word(8)); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rd_bubble_valid: got %b want 0", id_valid); end
        checks++; if (id_instruction !== NOP_W) begin errors++; $display("FAIL rd_bubble_instr: got %h want %h", id_instruction, NOP_W); end
        checks++; if (id_pc !== 32'h04) begin errors++; $display("FAIL rd_bubble_pc_hold: got %h want %h", id_pc, 32'h04); end
        checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL rd_bubble_count: got %h want 2", fetch_count); end
        checks++; if (misaligned_err !== 1'b0) begin errors++; $display("FAIL rd_aligned_err: got %b want 0", misaligned_err); end
        step();
        checks++; if (id_pc !== 32'h20) begin errors++; $display("FAIL rd_id_pc: got %h want %h", id_pc, 32'h20); end
        checks++; if (id_instruction !== rom_word(8)) begin errors++; $display("FAIL rd_id_instr: got %h want %h", id_instruction, rom_word(8)); end
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL rd_id_valid: got %b want 1", id_valid); end
        checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL rd_count: got %h want 3", fetch_count); end
        checks++; if (if_pc !== 32'h24) begin errors++; $display("FAIL rd_next_pc: got %h want %h", if_pc, 32'h24); end
    endtask

    task automatic test_stall();
        reset_dut();
        step();
        stall_if = 1'b1;
        stall_id = 1'b1;
        step();
        stall_if = 1'b0;
        stall_id = 1'b0;
        checks++; if (if_pc !== 32'h04) begin errors++; $display("FAIL st_if_pc: got %h want %h", if_pc, 32'h04); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL st_id_pc: got %h want %h", id_pc, 32'h0); end
        checks++; if (id_instruction !== rom_word(0)) begin errors++; $display("FAIL st_id_instr: got %h want %h", id_instruction, rom_word(0)); end
        checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL st_count: got %h want 1", fetch_count); end
        step();
        checks++; if (if_pc !== 32'h08) begin errors++; $display("FAIL st_resume_pc: got %h want %h", if_pc, 32'h08); end
        checks++; if (id_pc !== 32'h04) begin errors++; $display("FAIL st_resume_id_pc: got %h want %h", id_pc, 32'h04); end
        checks++; if (id_instruction !== rom_word(1)) begin errors++; $display("FAIL st_resume_instr: got %h want %h", id_instruction, rom_word(1)); end
        checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL st_resume_count: got %h want 2", fetch_count); end
    endtask

    task automatic test_flush();
        reset_dut();
        step();
        flush_id = 1'b1;
        stall_id = 1'b1;
        step();
        flush_id = 1'b0;
        stall_id = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %b want 0", id_valid); end
        checks++; if (id_instruction !== NOP_W) begin errors++; $display("FAIL fl_instr: got %h want %h", id_instruction, NOP_W); end
        checks++; if (id_pc_plus4 !== 32'h04) begin errors++; $display("FAIL fl_pc_plus4_hold: got %h want %h", id_pc_plus4, 32'h04); end
        checks++; if (if_pc !== 32'h08) begin errors++; $display("FAIL fl_if_pc: got %h want %h", if_pc, 32'h08); end
        checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL fl_count: got %h want 1", fetch_count); end
    endtask

    task automatic test_misaligned();
        reset_dut();
        step();
        stall_if = 1'b1;
        redirect_to(32'h13);
        stall_if = 1'b0;
        checks++; if (if_pc !== 32'h10) begin errors++; $display("FAIL mis_if_pc: got %h want %h", if_pc, 32'h10); end
        checks++; if (misaligned_err !== 1'b1) begin errors++; $display("FAIL mis_err_set: got %b want 1", misaligned_err); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL mis_bubble: got %b want 0", id_valid); end
        for (int i = 0; i < 3; i++) step();
        checks++; if (misaligned_err !== 1'b1) begin errors++; $display("FAIL mis_err_sticky: got %b want 1", misaligned_err); end
        checks++; if (if_pc !== 32'h1C) begin errors++; $display("FAIL mis_run_pc: got %h want %h", if_pc, 32'h1C); end
    endtask

    task automatic test_boundaries();
        reset_dut();
        redirect_to(32'h0000_0FFC);
        checks++; if (if_instruction !== rom_word(1023)) begin errors++; $display("FAIL bd_last_word: got %h want %h", if_instruction, rom_word(1023)); end
        step();
        checks++; if (if_pc !== 32'h0000_1000) begin errors++; $display("FAIL bd_oor_pc: got %h want %h", if_pc, 32'h1000); end
        checks++; if (if_instruction !== NOP_W) begin errors++; $display("FAIL bd_oor_instr: got %h want %h", if_instruction, NOP_W); end
        checks++;
        if ((^{if_pc, if_instruction, id_pc, id_pc_plus4, id_instruction, id_valid, misaligned_err, fetch_count}) === 1'bx) begin
            errors++; $display("FAIL bd_oor_no_x: got X on outputs want known values");
        end
        step();
        checks++; if (id_instruction !== NOP_W) begin errors++; $display("FAIL bd_oor_id_instr: got %h want %h", id_instruction, NOP_W); end
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL bd_oor_id_valid: got %b want 1", id_valid); end
        redirect_to(32'hFFFF_FFFC);
        checks++; if (if_instruction !== NOP_W) begin errors++; $display("FAIL bd_top_instr: got %h want %h", if_instruction, NOP_W); end
        step();
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL bd_wrap_pc: got %h want 0", if_pc); end
        checks++; if (id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL bd_wrap_pc_plus4: got %h want 0", id_pc_plus4); end
        checks++; if (id_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL bd_wrap_id_pc: got %h want %h", id_pc, 32'hFFFF_FFFC); end
    endtask

    task automatic test_async_reset();
        reset_dut();
        redirect_to(32'h0000_0041);
        step();
        stall_if        = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0080;
        #2;
        rst = 1'b0;
        #1;
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL ar_if_pc: got %h want 0", if_pc); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL ar_id_pc: got %h want 0", id_pc); end
        checks++; if (id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL ar_id_pc_plus4: got %h want 0", id_pc_plus4); end
        checks++; if (id_instruction !== NOP_W) begin errors++; $display("FAIL ar_id_instr: got %h want %h", id_instruction, NOP_W); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL ar_id_valid: got %b want 0", id_valid); end
        checks++; if (misaligned_err !== 1'b0) begin errors++; $display("FAIL ar_misaligned: got %b want 0", misaligned_err); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL ar_count: got %h want 0", fetch_count); end
        checks++; if (if_instruction !== rom_word(0)) begin errors++; $display("FAIL ar_rom_kept: got %h want %h", if_instruction, rom_word(0)); end
        step();
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL ar_held_pc: got %h want 0", if_pc); end
        idle_inputs();
        rst = 1'b1;
        step();
        checks++; if (id_instruction !== rom_word(0)) begin errors++; $display("FAIL ar_first_load: got %h want %h", id_instruction, rom_word(0)); end
        checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL ar_first_count: got %h want 1", fetch_count); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) dut.rom_memory[i] = rom_word(i);
        test_reset();
        test_linear();
        test_redirect();
        test_stall();
        test_flush();
        test_misaligned();
        test_boundaries();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
